// File: rtl/usart_rx_frame_ctrl_if.sv
// Host/receiver-side signal bundle for the USART frame controller.
// The controller takes the slave modport; the receiver/host side takes master.
interface usart_rx_frame_ctrl_if #(
    parameter int MAX_LEN = 16
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);

    logic [7:0]    rx_data;
    logic          rx_toggle;
    logic          frame_ack;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          frame_valid;
    logic [LW-1:0] frame_len;
    logic          busy;
    logic          err_length;
    logic          err_checksum;
    logic          err_timeout;
    logic          err_overrun;

    modport master (
        output rx_data, rx_toggle, frame_ack, rd_addr,
        input  rd_data, frame_valid, frame_len, busy,
               err_length, err_checksum, err_timeout, err_overrun
    );

    modport slave (
        input  rx_data, rx_toggle, frame_ack, rd_addr,
        output rd_data, frame_valid, frame_len, busy,
               err_length, err_checksum, err_timeout, err_overrun
    );
endinterface

// File: rtl/usart_rx_frame_ctrl.sv
// Frame-level receive controller: parses SOF, LEN, payload, XOR checksum from the
// USART byte stream, buffers the payload and holds a good frame until acknowledged.
module usart_rx_frame_ctrl #(
    parameter logic [7:0] SOF_BYTE     = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 100000
) (
    input logic                  clk,
    input logic                  reset,
    usart_rx_frame_ctrl_if.slave bus
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_DONE
    } state_t;

    state_t        r_state, w_nxt;
    logic          r_toggle_q, r_armed;
    logic [LW-1:0] r_len, r_idx, r_frame_len;
    logic [7:0]    r_csum, r_rd_data;
    logic [TW-1:0] r_tmo;
    logic [7:0]    r_buf [MAX_LEN];
    logic          r_err_len, r_err_cs, r_err_tmo, r_err_ovr;

    logic w_evt, w_mid, w_tmo_hit, w_len_ok, w_last, w_csum_ok;
    logic w_err_len, w_err_cs, w_err_tmo, w_err_ovr;

    // armed suppresses the bogus edge seen when rx_toggle is already high at reset release
    assign w_evt     = r_armed && (bus.rx_toggle != r_toggle_q);
    assign w_mid     = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CSUM);
    assign w_tmo_hit = (r_tmo == TMO_LAST);
    assign w_len_ok  = (bus.rx_data != 8'h00) && (bus.rx_data <= MAX_LEN_B);
    assign w_last    = (r_idx == (r_len - LW'(1)));
    assign w_csum_ok = (bus.rx_data == r_csum);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_toggle_q <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_toggle_q <= bus.rx_toggle;
            r_armed    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    // A byte event always outranks a timeout in the same cycle.
    always_comb begin
        w_nxt     = r_state;
        w_err_len = 1'b0;
        w_err_cs  = 1'b0;
        w_err_tmo = 1'b0;
        w_err_ovr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_evt && (bus.rx_data == SOF_BYTE)) w_nxt = S_LEN;
            end
            S_LEN: begin
                if (w_evt) begin
                    if (w_len_ok) begin
                        w_nxt = S_PAYLOAD;
                    end else begin
                        w_err_len = 1'b1;
                        w_nxt     = S_IDLE;
                    end
                end else if (w_tmo_hit) begin
                    w_err_tmo = 1'b1;
                    w_nxt     = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (w_evt) begin
                    if (w_last) w_nxt = S_CSUM;
                end else if (w_tmo_hit) begin
                    w_err_tmo = 1'b1;
                    w_nxt     = S_IDLE;
                end
            end
            S_CSUM: begin
                if (w_evt) begin
                    if (w_csum_ok) begin
                        w_nxt = S_DONE;
                    end else begin
                        w_err_cs = 1'b1;
                        w_nxt    = S_IDLE;
                    end
                end else if (w_tmo_hit) begin
                    w_err_tmo = 1'b1;
                    w_nxt     = S_IDLE;
                end
            end
            S_DONE: begin
                if (w_evt)         w_err_ovr = 1'b1;
                if (bus.frame_ack) w_nxt     = S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len       <= '0;
            r_idx       <= '0;
            r_csum      <= '0;
            r_frame_len <= '0;
            r_tmo       <= '0;
            r_rd_data   <= '0;
            r_err_len   <= 1'b0;
            r_err_cs    <= 1'b0;
            r_err_tmo   <= 1'b0;
            r_err_ovr   <= 1'b0;
        end else begin
            r_err_len <= w_err_len;
            r_err_cs  <= w_err_cs;
            r_err_tmo <= w_err_tmo;
            r_err_ovr <= w_err_ovr;
            r_rd_data <= r_buf[bus.rd_addr];
            if (w_evt) begin
                case (r_state)
                    S_LEN: begin
                        if (w_len_ok) begin
                            r_len  <= bus.rx_data[LW-1:0];
                            r_csum <= bus.rx_data;
                            r_idx  <= '0;
                        end
                    end
                    S_PAYLOAD: begin
                        r_csum <= r_csum ^ bus.rx_data;
                        r_idx  <= r_idx + LW'(1);
                    end
                    S_CSUM: begin
                        if (w_csum_ok) r_frame_len <= r_len;
                    end
                    default: ;
                endcase
            end
            // Counter only advances while waiting in a mid-frame state.
            if (!w_mid || w_evt || (w_nxt != r_state)) r_tmo <= '0;
            else                                         r_tmo <= r_tmo + TW'(1);
        end
    end

    // Payload store; only written in PAYLOAD, so it stays frozen while a frame is held.
    always_ff @(posedge clk) begin
        if (w_evt && (r_state == S_PAYLOAD)) r_buf[r_idx[AW-1:0]] <= bus.rx_data;
    end

    assign bus.rd_data      = r_rd_data;
    assign bus.frame_valid  = (r_state == S_DONE);
    assign bus.frame_len    = r_frame_len;
    assign bus.busy         = w_mid;
    assign bus.err_length   = r_err_len;
    assign bus.err_checksum = r_err_cs;
    assign bus.err_timeout  = r_err_tmo;
    assign bus.err_overrun  = r_err_ovr;
endmodule

// File: tb/tb_usart_rx_frame_ctrl.sv
// Bench for usart_rx_frame_ctrl: directed vector table, randomized frames scored
// against expectations derived from how each frame was built, and corner sequences.
module tb_usart_rx_frame_ctrl;
  localparam int MAX_LEN = 16;
  localparam int TMO     = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  usart_rx_frame_ctrl_if #(.MAX_LEN(MAX_LEN)) bus();

  usart_rx_frame_ctrl #(
    .SOF_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk(clk), .reset(rst_n), .bus(bus.slave)
  );

  int n_cmp = 0, n_bad = 0;
  int c_len = 0, c_cs = 0, c_tmo = 0, c_ovr = 0, c_multi = 0;

  always @(negedge clk) begin
    c_len += int'(bus.err_length);
    c_cs  += int'(bus.err_checksum);
    c_tmo += int'(bus.err_timeout);
    c_ovr += int'(bus.err_overrun);
    if (int'(bus.err_length) + int'(bus.err_checksum) + int'(bus.err_timeout) + int'(bus.err_overrun) > 1)
      c_multi++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a byte and let the edge that consumes it pass.
  task automatic send_byte(input logic [7:0] b, input int gap);
    if (gap > 0) tick(gap);
    bus.rx_data   = b;
    bus.rx_toggle = ~bus.rx_toggle;
    tick(1);
  endtask

  task automatic read_check(input int addr, input logic [7:0] exp, input string name);
    bus.rd_addr = 4'(addr);
    tick(1);
    check(name, bus.rd_data, exp);
  endtask

  task automatic do_ack(input string name);
    bus.frame_ack = 1'b1;
    tick(1);
    bus.frame_ack = 1'b0;
    check(name, bus.frame_valid, 0);
  endtask

  typedef struct {
    int         n;
    logic [7:0] b [10];
    int         e_len;
    int         e_cs;
    logic       e_valid;
    int         e_flen;
    logic [7:0] e_pay [4];
  } vec_t;

  vec_t vt [5];
  logic [7:0] q [$];
  logic [7:0] pay [MAX_LEN];
  int l0, cs0, t0, o0;
  int kind, len, nov, k_hit, n_hits, spur;
  logic [7:0] x, bb;

  initial begin
    vt[0].n = 6; vt[0].b = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 0, 0, 0, 0};
    vt[0].e_len = 0; vt[0].e_cs = 0; vt[0].e_valid = 1'b1; vt[0].e_flen = 3;
    vt[0].e_pay = '{8'h11, 8'h22, 8'h33, 0};
    vt[1].n = 5; vt[1].b = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31, 0, 0, 0, 0, 0};
    vt[1].e_len = 0; vt[1].e_cs = 1; vt[1].e_valid = 1'b0; vt[1].e_flen = 0;
    vt[1].e_pay = '{0, 0, 0, 0};
    vt[2].n = 2; vt[2].b = '{8'hA5, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[2].e_len = 1; vt[2].e_cs = 0; vt[2].e_valid = 1'b0; vt[2].e_flen = 0;
    vt[2].e_pay = '{0, 0, 0, 0};
    vt[3].n = 2; vt[3].b = '{8'hA5, 8'h11, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[3].e_len = 1; vt[3].e_cs = 0; vt[3].e_valid = 1'b0; vt[3].e_flen = 0;
    vt[3].e_pay = '{0, 0, 0, 0};
    vt[4].n = 7; vt[4].b = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h7F, 0, 0, 0};
    vt[4].e_len = 0; vt[4].e_cs = 0; vt[4].e_valid = 1'b1; vt[4].e_flen = 1;
    vt[4].e_pay = '{8'h7E, 0, 0, 0};

    bus.rx_data = 8'h00; bus.rx_toggle = 1'b0; bus.frame_ack = 1'b0; bus.rd_addr = '0;

    // reset values
    #12;
    check("rst_busy",  bus.busy, 0);
    check("rst_valid", bus.frame_valid, 0);
    check("rst_flen",  bus.frame_len, 0);
    check("rst_rdata", bus.rd_data, 0);
    check("rst_errs",  {bus.err_length, bus.err_checksum, bus.err_timeout, bus.err_overrun}, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    tick(1);

    // directed table
    for (int i = 0; i < 5; i++) begin
      l0 = c_len; cs0 = c_cs; t0 = c_tmo; o0 = c_ovr;
      for (int j = 0; j < vt[i].n; j++) send_byte(vt[i].b[j], 1);
      tick(2);
      check($sformatf("tbl%0d_err_len", i), c_len - l0, vt[i].e_len);
      check($sformatf("tbl%0d_err_cs", i), c_cs - cs0, vt[i].e_cs);
      check($sformatf("tbl%0d_other_err", i), (c_tmo - t0) + (c_ovr - o0), 0);
      check($sformatf("tbl%0d_valid", i), bus.frame_valid, vt[i].e_valid);
      check($sformatf("tbl%0d_busy", i), bus.busy, 0);
      if (vt[i].e_valid) begin
        check($sformatf("tbl%0d_flen", i), bus.frame_len, vt[i].e_flen);
        for (int j = 0; j < vt[i].e_flen; j++)
          read_check(j, vt[i].e_pay[j], $sformatf("tbl%0d_rd%0d", i, j));
        do_ack($sformatf("tbl%0d_ack", i));
      end
    end

    // timeout: err_timeout 50 cycles after the last byte, then recovery
    send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h10, 1);
    k_hit = -1; n_hits = 0;
    for (int k = 1; k <= 60; k++) begin
      tick(1);
      if (bus.err_timeout) begin
        n_hits++;
        if (k_hit < 0) k_hit = k;
      end
    end
    check("tmo_cycle", k_hit, TMO);
    check("tmo_count", n_hits, 1);
    check("tmo_busy",  bus.busy, 0);
    send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h7E, 1); send_byte(8'h7F, 1);
    tick(1);
    check("tmo_recover_valid", bus.frame_valid, 1);
    read_check(0, 8'h7E, "tmo_recover_rd0");
    do_ack("tmo_recover_ack");

    // overrun while holding, then ack coinciding with a byte
    send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'hC3, 1); send_byte(8'h3C, 1);
    send_byte(8'hFD, 1);
    o0 = c_ovr;
    send_byte(8'h55, 1); send_byte(8'h66, 0);
    tick(2);
    check("ovr_count", c_ovr - o0, 2);
    check("ovr_valid", bus.frame_valid, 1);
    check("ovr_flen",  bus.frame_len, 2);
    read_check(0, 8'hC3, "ovr_rd0");
    read_check(1, 8'h3C, "ovr_rd1");
    bus.rx_data = 8'hA5; bus.rx_toggle = ~bus.rx_toggle; bus.frame_ack = 1'b1;
    tick(1);
    bus.frame_ack = 1'b0;
    check("ovr_ack_pulse", bus.err_overrun, 1);
    check("ovr_ack_valid", bus.frame_valid, 0);
    check("ovr_ack_busy",  bus.busy, 0);
    l0 = c_len;
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h7E, 0); send_byte(8'h7F, 0);
    tick(1);
    check("b2b_valid", bus.frame_valid, 1);
    check("b2b_no_len_err", c_len - l0, 0);
    read_check(0, 8'h7E, "b2b_rd0");
    do_ack("b2b_ack");

    // randomized frames
    for (int f = 0; f < 120; f++) begin
      kind = int'($urandom_range(0, 3));
      q.delete();
      len = 0;
      case (kind)
        0, 1: begin
          len = int'($urandom_range(1, MAX_LEN));
          x = 8'(len);
          q.push_back(8'hA5); q.push_back(8'(len));
          for (int i = 0; i < len; i++) begin
            pay[i] = 8'($urandom);
            x ^= pay[i];
            q.push_back(pay[i]);
          end
          q.push_back((kind == 0) ? x : (x ^ 8'($urandom_range(1, 255))));
        end
        2: begin
          q.push_back(8'hA5);
          q.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
        end
        default: begin
          for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
            bb = 8'($urandom);
            if (bb == 8'hA5) bb = 8'h5A;
            q.push_back(bb);
          end
        end
      endcase
      l0 = c_len; cs0 = c_cs; t0 = c_tmo; o0 = c_ovr;
      foreach (q[i]) send_byte(q[i], int'($urandom_range(0, 4)));
      tick(2);
      check($sformatf("rnd%0d_err_len", f), c_len - l0, (kind == 2) ? 1 : 0);
      check($sformatf("rnd%0d_err_cs", f), c_cs - cs0, (kind == 1) ? 1 : 0);
      check($sformatf("rnd%0d_valid", f), bus.frame_valid, (kind == 0) ? 1 : 0);
      check($sformatf("rnd%0d_busy", f), bus.busy, 0);
      if (kind == 0) begin
        nov = int'($urandom_range(0, 2));
        for (int i = 0; i < nov; i++) send_byte(8'($urandom), int'($urandom_range(0, 2)));
        tick(2);
        check($sformatf("rnd%0d_ovr", f), c_ovr - o0, nov);
        check($sformatf("rnd%0d_flen", f), bus.frame_len, len);
        for (int i = 0; i < len; i++) read_check(i, pay[i], $sformatf("rnd%0d_rd%0d", f, i));
        do_ack($sformatf("rnd%0d_ack", f));
      end
      check($sformatf("rnd%0d_tmo", f), c_tmo - t0, 0);
    end

    // async reset mid-payload, with rx_toggle high at release
    bus.rd_addr = '0;
    send_byte(8'hA5, 1); send_byte(8'h04, 1); send_byte(8'h01, 1); send_byte(8'h02, 1);
    check("rstm_busy_before", bus.busy, 1);
    #3;
    rst_n = 1'b0;
    bus.rx_data = 8'hA5;
    bus.rx_toggle = 1'b1;
    #1;
    check("rstm_busy",  bus.busy, 0);
    check("rstm_valid", bus.frame_valid, 0);
    check("rstm_flen",  bus.frame_len, 0);
    check("rstm_rdata", bus.rd_data, 0);
    check("rstm_errs",  {bus.err_length, bus.err_checksum, bus.err_timeout, bus.err_overrun}, 0);
    tick(2);
    #2 rst_n = 1'b1;
    spur = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      if (bus.busy || bus.err_length) spur++;
    end
    check("rstm_no_spurious", spur, 0);
    send_byte(8'hA5, 1); send_byte(8'h03, 1); send_byte(8'h11, 1);
    send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h03, 1);
    tick(1);
    check("rstm_recover_valid", bus.frame_valid, 1);
    check("rstm_recover_flen",  bus.frame_len, 3);
    read_check(2, 8'h33, "rstm_recover_rd2");
    do_ack("rstm_recover_ack");

    tick(2);
    check("multi_err", c_multi, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/usart_rx_frame_ctrl.md
# usart_rx_frame_ctrl

Frame-level receive controller that sits directly behind the USART receiver and sequences its byte stream into validated command frames. It detects each received byte from the receiver's toggling `enable` output and parses the frame format SOF, LEN, payload, XOR checksum. It stores the payload in an internal buffer and holds a good frame until the host acknowledges it. Malformed, stalled and overrunning traffic is discarded, and each case is flagged with an error pulse.

## Interface
- `SOF_BYTE`, 8'hA5, start-of-frame marker
- `MAX_LEN`, 16, maximum payload length in bytes (1..255)
- `TIMEOUT_CLKS`, 100000, inter-byte timeout in `clk` cycles, applied in mid-frame states
- `clk`  input  1  system clock; all logic is on the rising edge
- `reset`  input  1  asynchronous, active-low reset
- `rx_data`  input  8  byte from the USART receiver's data output
- `rx_toggle`  input  1  receiver's `enable` output; every change of level marks one new byte on `rx_data`
- `frame_ack`  input  1  host releases the held frame
- `rd_addr`  input  $clog2(MAX_LEN)  payload buffer read address
- `rd_data`  output  8  registered buffer read data
- `frame_valid`  output  1  level; a good frame is held
- `frame_len`  output  $clog2(MAX_LEN+1)  payload length of the held frame
- `busy`  output  1  high in LEN, PAYLOAD and CSUM
- `err_length`, `err_checksum`, `err_timeout`, `err_overrun`  output  1 each  one-cycle error pulses

## Operation
- **Byte event.** Register `toggle_q`; an event occurs when `rx_toggle != toggle_q`. On the first cycle after reset release, `toggle_q` loads `rx_toggle` without raising an event (the `armed` flag).
- **IDLE.** A byte equal to `SOF_BYTE` moves to LEN. Any other byte is dropped silently.
- **LEN.**
  - Byte 0 or byte > `MAX_LEN`: pulse `err_length`, go to IDLE.
  - Otherwise: `len` = byte, `csum` = byte, `idx` = 0, go to PAYLOAD.
- **PAYLOAD.** Per byte: `buf[idx]` = byte, `csum` ^= byte, `idx`++. After the byte with `idx == len-1` is written, go to CSUM.
- **CSUM.**
  - Byte == `csum`: go to DONE; `frame_valid` = 1; `frame_len` = `len`.
  - Byte != `csum`: pulse `err_checksum`, go to IDLE.
- **DONE.**
  - The buffer is frozen.
  - Each byte event pulses `err_overrun` and the byte is dropped, including a byte that arrives in the same cycle as `frame_ack`.
  - `frame_ack` = 1 returns the block to IDLE.
  - `frame_ack` is ignored in all other states.
- **Timeout.**
  - A counter runs in LEN, PAYLOAD and CSUM and clears on every byte event and on every state entry.
  - When the counter reaches `TIMEOUT_CLKS-1` with no byte event: pulse `err_timeout`, go to IDLE.
  - A byte event in the same cycle as the timeout wins: the byte is processed and the counter clears.
- **Buffer.** `MAX_LEN` x 8 registers, with no reset required. A read of `rd_addr` ≥ `frame_len` returns stale contents.
- **Priority.** Reset overrides everything. At most one error pulse is raised per cycle.

## Timing
- Values on reset assertion:
  - state = IDLE
  - `frame_valid`, `busy`, all `err_*` = 0
  - `frame_len` = 0, `rd_data` = 0
  - `toggle_q` = 0, `armed` = 0, counters = 0
- The state update happens on the first rising edge at which `rx_toggle != toggle_q`. That is 1 cycle after the receiver toggles `enable`.
- `frame_valid` rises at the edge that consumes a correct checksum byte. It falls at the edge after `frame_ack` is sampled high in DONE.
- `rd_data` = `buf[rd_addr]`, registered, with 1-cycle latency. It is valid in every state, but contents are only guaranteed while `frame_valid` = 1.
- Error pulses are exactly 1 cycle wide, asserted at the edge that detects the error.
- Back-to-back frames are supported: after `frame_ack`, an SOF byte on the very next byte event is accepted.
- Reset asserted mid-frame: all outputs are forced to their reset values immediately (asynchronously), and the partial frame is lost.

## Test plan
- **Good frame.** Send A5 03 11 22 33 03 -> `frame_valid` = 1, `frame_len` = 3; `rd_addr` 0/1/2 gives `rd_data` 11/22/33 one cycle later; `frame_ack` drops `frame_valid` the next cycle.
- **Bad checksum and framing errors.**
  - A5 02 10 20 31 -> `err_checksum` pulses once, `frame_valid` stays 0, `busy` = 0 afterwards.
  - A5 00 -> `err_length`.
  - A5 11 (with `MAX_LEN` = 16) -> `err_length`.
  - Leading junk 00 FF 5A before a good frame -> no errors, and the frame is accepted.
- **Timeout.** `TIMEOUT_CLKS` = 50; send A5 02 10, then idle 50 cycles -> `err_timeout` pulses at cycle 50 after the last event. Then a good frame A5 01 7E 7F is accepted.
- **Overrun.** While holding a frame, send 2 bytes -> 2 `err_overrun` pulses, buffer unchanged. `frame_ack` asserted in the same cycle as a byte event -> overrun pulse, and the block returns to IDLE.
- **Reset.** Assert `reset` low mid-PAYLOAD -> outputs go to reset values without a clock edge. After release, the `rx_toggle` level (0 or 1) produces no spurious byte, and the next good frame is accepted.
